// File: rtl/aes128_iter_core.sv
// rtl/aes128_iter_core.sv - iterative AES-128 encryption core computing UNROLL rounds per clock
// Build option: AES_ITER_ZEROIZE_EN clears st, rk and ciphertext on the output handshake.
module aes128_iter_core #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy
);
    localparam int NR = 10;
    localparam logic [3:0] NR_W     = 4'(NR);
    localparam logic [3:0] UNROLL_W = 4'(UNROLL);

    generate
        if (NR != 10 || !(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_cfg
            $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    state_t         state_nx;
    logic [127:0]   st;
    logic [127:0]   rk;
    logic [3:0]     rc;
    logic [3:0]     round_idx;
    logic [127:0]   st_chain [UNROLL+1];
    logic [127:0]   rk_chain [UNROLL+1];
    logic           last_step;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (product of x^2 .. x^128), then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rcon);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Byte i of the block is row i%4, column i/4
    function automatic logic [127:0] round_fn(input logic [127:0] s_in, input logic [127:0] k,
                                              input logic final_rnd);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] s_out;
        for (int i = 0; i < 16; i++) b[i] = sbox(s_in[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r+4*c] = b[r+4*((c+r)%4)];
        if (!final_rnd) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c];   a1 = t[4*c+1];
                a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end
        for (int i = 0; i < 16; i++) s_out[127-8*i -: 8] = t[i];
        return s_out ^ k;
    endfunction

    always_comb begin
        round_idx   = rc;
        st_chain[0] = st;
        rk_chain[0] = rk;
        for (int u = 0; u < UNROLL; u++) begin
            round_idx     = rc + 4'(u);
            rk_chain[u+1] = key_next(rk_chain[u], rcon_of(round_idx));
            st_chain[u+1] = round_fn(st_chain[u], rk_chain[u+1], round_idx == NR_W);
        end
    end

    assign last_step = (rc + UNROLL_W - 4'd1) == NR_W;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last_step) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == RUN) || (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= '0;
            rk         <= '0;
            rc         <= '0;
            ciphertext <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st <= plaintext ^ key;
                        rk <= key;
                        rc <= 4'd1;
                    end
                end
                RUN: begin
                    st <= st_chain[UNROLL];
                    rk <= rk_chain[UNROLL];
                    if (last_step) begin
                        ciphertext <= st_chain[UNROLL];
                        rc         <= NR_W;
                    end else begin
                        rc <= rc + UNROLL_W;
                    end
                end
                DONE: begin
`ifdef AES_ITER_ZEROIZE_EN
                    if (out_ready) begin
                        st         <= '0;
                        rk         <= '0;
                        ciphertext <= '0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes128_iter_core.sv
// tb/tb_aes128_iter_core.sv - randomized self-checking bench for aes128_iter_core against a byte-array AES model
module tb_aes128_iter_core;
    localparam int UNROLL = 1;
    localparam int LAT    = 10 / UNROLL;

    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;

    logic         aux_valid;
    logic         aux_ordy;
    logic [127:0] aux_pt;
    logic [127:0] aux_key;
    logic [2:0]   aux_ir;
    logic [2:0]   aux_ov;
    logic [2:0]   aux_busy;
    logic [127:0] aux_ct [3];

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    logic [7:0] sb [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes128_iter_core #(.UNROLL(UNROLL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
        .ciphertext(ciphertext), .busy(busy)
    );

    for (genvar k = 0; k < 3; k++) begin : g_aux
        localparam int AU = (k == 0) ? 2 : ((k == 1) ? 5 : 10);
        aes128_iter_core #(.UNROLL(AU)) u_aux (
            .clk(clk), .rst(rst), .in_valid(aux_valid), .in_ready(aux_ir[k]),
            .plaintext(aux_pt), .key(aux_key), .out_valid(aux_ov[k]), .out_ready(aux_ordy),
            .ciphertext(aux_ct[k]), .busy(aux_busy[k])
        );
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    endtask

    function automatic logic [7:0] mul2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Walk the multiplicative group with generator 3 and its inverse to fill the S-box
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ mul2(p);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rcon;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp  = {sb[tmp[23:16]] ^ rcon, sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]};
                rcon = mul2(rcon);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int rd = 0; rd <= 10; rd++) begin
            if (rd > 0) begin
                for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
                if (rd < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = mul2(a0) ^ mul2(a1) ^ a1 ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ mul2(a1) ^ mul2(a2) ^ a2 ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ mul2(a2) ^ mul2(a3) ^ a3;
                        s[4*c+3] = mul2(a0) ^ a0 ^ a1 ^ a2 ^ mul2(a3);
                    end
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r+4*c] = s[r+4*c] ^ w[4*rd+c][31-8*r -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_accept(input logic [127:0] pt, input logic [127:0] k);
        int n;
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_at_accept", 128'(in_ready), 128'(1));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_seen", 128'(out_valid), 128'(1));
        lat = n;
    endtask

    task automatic handshake(input int stall);
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int           lat;
        int           rwait;
        int           nacc;
        int           nres;
        int           last_acc;
        int           aux_lat [3];
        logic [2:0]   aux_seen;
        logic [127:0] aux_got [3];
        logic [127:0] pa, ka, pb, kb, ea, eb;
        logic [127:0] exp_q [$];

        build_sbox();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; key = '0;
        aux_valid = 1'b0; aux_ordy = 1'b1; aux_pt = '0; aux_key = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_ct", ciphertext, 128'(0));
        check("rst_rc", 128'(dut.rc), 128'(0));

        // FIPS-197 App.B with latency measurement
        do_accept(B_PT, B_KEY);
        check("appB_busy", 128'(busy), 128'(1));
        check("appB_in_ready_low", 128'(in_ready), 128'(0));
        wait_out(lat);
        check("appB_latency", 128'(lat), 128'(LAT));
        check("appB_ct", ciphertext, B_CT);
        handshake(0);
        check("appB_post_ov", 128'(out_valid), 128'(0));
        check("appB_post_ir", 128'(in_ready), 128'(1));
`ifdef AES_ITER_ZEROIZE_EN
        check("zero_ct", ciphertext, 128'(0));
        check("zero_st", dut.st, 128'(0));
        check("zero_rk", dut.rk, 128'(0));
`else
        check("hold_ct", ciphertext, B_CT);
`endif

        // FIPS-197 App.C.1 on this instance and on UNROLL=2,5,10 instances
        do_accept(C_PT, C_KEY);
        wait_out(lat);
        check("appC_latency", 128'(lat), 128'(LAT));
        check("appC_ct", ciphertext, C_CT);
        handshake(0);

        check("aux_idle", 128'(aux_ir), 128'(3'b111));
        aux_pt = C_PT; aux_key = C_KEY; aux_valid = 1'b1;
        @(negedge clk);
        aux_valid = 1'b0;
        aux_pt = rand128(); aux_key = rand128();
        aux_seen = 3'b000;
        for (int k = 0; k < 3; k++) begin
            aux_lat[k] = -1;
            aux_got[k] = '0;
        end
        for (int n = 0; n < 15; n++) begin
            for (int k = 0; k < 3; k++) begin
                if (aux_ov[k] && !aux_seen[k]) begin
                    aux_seen[k] = 1'b1;
                    aux_lat[k]  = n;
                    aux_got[k]  = aux_ct[k];
                end
            end
            @(negedge clk);
        end
        check("aux_u2_ct", aux_got[0], C_CT);
        check("aux_u2_lat", 128'(aux_lat[0]), 128'(5));
        check("aux_u5_ct", aux_got[1], C_CT);
        check("aux_u5_lat", 128'(aux_lat[1]), 128'(2));
        check("aux_u10_ct", aux_got[2], C_CT);
        check("aux_u10_lat", 128'(aux_lat[2]), 128'(1));

        // Backpressure: hold DONE for 7 cycles while a second block waits on the input
        pa = rand128(); ka = rand128(); pb = rand128(); kb = rand128();
        ea = ref_aes(pa, ka); eb = ref_aes(pb, kb);
        do_accept(pa, ka);
        wait_out(lat);
        plaintext = pb; key = kb; in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check("bp_out_valid", 128'(out_valid), 128'(1));
            check("bp_ct_stable", ciphertext, ea);
            check("bp_in_ready", 128'(in_ready), 128'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_reaccept_ir", 128'(in_ready), 128'(1));
        check("bp_reaccept_ov", 128'(out_valid), 128'(0));
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_second_busy", 128'(busy), 128'(1));
        wait_out(lat);
        check("bp_second_ct", ciphertext, eb);
        handshake(0);

        // Reset in the middle of a run
        rwait = (LAT > 4) ? 4 : LAT - 1;
        do_accept(rand128(), rand128());
        repeat (rwait) @(negedge clk);
        check("mr_busy_before", 128'(busy), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mr_out_valid", 128'(out_valid), 128'(0));
        check("mr_in_ready", 128'(in_ready), 128'(1));
        check("mr_busy", 128'(busy), 128'(0));
        do_accept(B_PT, B_KEY);
        wait_out(lat);
        check("mr_appB_ct", ciphertext, B_CT);
        handshake(0);

        // Back-to-back stream; inputs scrambled every cycle a block is not being accepted
        out_ready = 1'b1; in_valid = 1'b1;
        plaintext = rand128(); key = rand128();
        nacc = 0; nres = 0; last_acc = 0;
        for (int i = 0; i < 200 && nres < 4; i++) begin
            if (out_valid) begin
                if (exp_q.size() > 0) check("b2b_ct", ciphertext, exp_q.pop_front());
                else check("b2b_unexpected_out", 128'(out_valid), 128'(0));
                nres++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_aes(plaintext, key));
                if (nacc > 0) check("b2b_spacing", 128'(cyc - last_acc), 128'(LAT + 2));
                last_acc = cyc;
                nacc++;
            end else begin
                in_valid  = (nacc < 4);
                plaintext = rand128();
                key       = rand128();
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_results", 128'(nres), 128'(4));

        // Random single blocks with random sink stall
        for (int j = 0; j < 6; j++) begin
            pa = rand128(); ka = rand128();
            ea = ref_aes(pa, ka);
            do_accept(pa, ka);
            plaintext = rand128(); key = rand128();
            wait_out(lat);
            check("rnd_latency", 128'(lat), 128'(LAT));
            check("rnd_ct", ciphertext, ea);
            handshake(int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
